rr_mux_arbiter: RTL

Round-robin arbiter that shares one 4:1 multiplexer datapath among four requesters.
- Each requester raises a request line. The block grants one requester at a time and drives the mux select. The selected requester's data is presented on a single shared output with a valid flag.
- Grants are held while the requester keeps its request, up to a bounded tenure. The grant then rotates to the next pending requester.
- Sits between four data sources and one shared single-channel consumer.

---
 rtl/arb_defs.sv | 20 ++
 rtl/rr_mux_arbiter_if.sv | 27 ++
 rtl/rr_mux_arbiter_mux4_w.sv | 24 ++
 rtl/rr_mux_arbiter.sv | 115 +++++++++++
 4 files changed

// File: rtl/arb_defs.sv
// Shared definitions for the round-robin mux arbiter: state encoding,
// requester count, select width and a one-hot helper.
package arb_defs;

    localparam int NUM_REQ = 4;
    localparam int SEL_W   = 2;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_e;

    typedef logic [NUM_REQ-1:0] req_t;
    typedef logic [SEL_W-1:0]   sel_t;

    function automatic req_t onehot(input sel_t s);
        return req_t'(1) << s;
    endfunction

endpackage

// File: rtl/rr_mux_arbiter_if.sv
// Requester-side and consumer-side signals of the shared mux arbiter.
// The master modport is the requester/consumer side, slave is the arbiter.
interface rr_mux_arbiter_if #(parameter int DATA_W = 1);
    import arb_defs::*;

    req_t              req;
    logic [DATA_W-1:0] din0;
    logic [DATA_W-1:0] din1;
    logic [DATA_W-1:0] din2;
    logic [DATA_W-1:0] din3;
    req_t              gnt;
    sel_t              sel;
    logic [DATA_W-1:0] dout;
    logic              dout_valid;
    logic              busy;

    modport master (
        output req, din0, din1, din2, din3,
        input  gnt, sel, dout, dout_valid, busy
    );

    modport slave (
        input  req, din0, din1, din2, din3,
        output gnt, sel, dout, dout_valid, busy
    );

endinterface

// File: rtl/rr_mux_arbiter_mux4_w.sv
// DATA_W-wide 4:1 combinational multiplexer.
module mux4_w
    import arb_defs::*;
#(
    parameter int DATA_W = 1
) (
    input  logic [DATA_W-1:0] din0,
    input  logic [DATA_W-1:0] din1,
    input  logic [DATA_W-1:0] din2,
    input  logic [DATA_W-1:0] din3,
    input  sel_t              sel,
    output logic [DATA_W-1:0] dout
);

    always_comb begin
        case (sel)
            2'd0:    dout = din0;
            2'd1:    dout = din1;
            2'd2:    dout = din2;
            default: dout = din3;
        endcase
    end

endmodule

// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter sharing one 4:1 mux among four requesters, with a
// bounded grant tenure whenever another requester is waiting.
module rr_mux_arbiter
    import arb_defs::*;
#(
    parameter int DATA_W   = 1,
    parameter int MAX_HOLD = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    rr_mux_arbiter_if.slave     bus
);

    typedef logic [7:0] hold_t;
    localparam hold_t HOLD_LAST = hold_t'(MAX_HOLD - 1);

    state_e state_q, state_d;
    req_t   gnt_q,   gnt_d;
    sel_t   sel_q,   sel_d;
    sel_t   ptr_q,   ptr_d;
    hold_t  hold_q,  hold_d;

    logic [SEL_W:0]    pick;
    req_t              others;
    logic              release_now;
    logic              busy;
    logic              dout_valid;
    logic [DATA_W-1:0] mux_out;

    // Returns {found, index} of the first set bit of r, searching circularly from start.
    function automatic logic [SEL_W:0] rr_pick(input req_t r, input sel_t start);
        logic [SEL_W:0] res;
        sel_t           idx;
        res = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            idx = start + sel_t'(i);
            if (r[idx]) res = {1'b1, idx};
        end
        return res;
    endfunction

    always_comb begin
        // NOTE: every variable written here gets a default first, so no latch is inferred.
        state_d     = state_q;
        gnt_d       = gnt_q;
        sel_d       = sel_q;
        ptr_d       = ptr_q;
        hold_d      = hold_q;
        pick        = '0;
        others      = bus.req & ~onehot(sel_q);
        release_now = 1'b0;

        if (state_q == IDLE) begin
            pick = rr_pick(bus.req, ptr_q);
            if (pick[SEL_W]) begin
                state_d = GRANT;
                sel_d   = pick[SEL_W-1:0];
                gnt_d   = onehot(pick[SEL_W-1:0]);
                hold_d  = '0;
            end
        end else begin
            release_now = !bus.req[sel_q] || (hold_q == HOLD_LAST && others != '0);
            if (release_now) begin
                ptr_d  = sel_q + sel_t'(1);
                hold_d = '0;
                pick   = rr_pick(others, sel_q + sel_t'(1));
                if (pick[SEL_W]) begin
                    sel_d = pick[SEL_W-1:0];
                    gnt_d = onehot(pick[SEL_W-1:0]);
                end else begin
                    state_d = IDLE;
                    gnt_d   = '0;
                end
            end else begin
                // A lone holder at the tenure limit keeps the grant and restarts its count.
                hold_d = (hold_q == HOLD_LAST) ? '0 : hold_q + hold_t'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values.
        if (!rst_n) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            sel_q   <= '0;
            ptr_q   <= '0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            sel_q   <= sel_d;
            ptr_q   <= ptr_d;
            hold_q  <= hold_d;
        end
    end

    mux4_w #(.DATA_W(DATA_W)) u_mux (
        .din0 (bus.din0),
        .din1 (bus.din1),
        .din2 (bus.din2),
        .din3 (bus.din3),
        .sel  (sel_q),
        .dout (mux_out)
    );

    assign busy           = (state_q == GRANT);
    assign dout_valid     = busy & bus.req[sel_q];
    assign bus.gnt        = gnt_q;
    assign bus.sel        = sel_q;
    assign bus.busy       = busy;
    assign bus.dout_valid = dout_valid;
    assign bus.dout       = dout_valid ? mux_out : '0;

endmodule
